spi_target: RTL and testbench

//  SPI target (slave) end of the board SPI link: mode 0 (CPOL=0, CPHA=0), MSB first, WIDTH-bit words.
//  All SPI pins are oversampled in the clk_in domain; the master's sclk is never used as a clock.

---
 rtl/spi_target_if.sv | 36 +++
 rtl/spi_target.sv | 161 ++++++++++++++++
 tb/tb_spi_target.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_target_if.sv
// rtl/spi_target_if.sv - SPI pin and host-side handshake bundle for spi_target
// Purpose: groups the SPI pads and the host TX/RX handshake into one bundle.
// Signals:
//   sclk, cs, sdi       SPI pins from the master (async to clk_in)
//   sdo, sdo_oe         SPI data to the master and its pad enable
//   tx_data/tx_valid/tx_ready   host word into the TX holding register
//   rx_data/rx_valid    last received word and its one-cycle strobe
//   tx_underrun         one-cycle strobe, word started with nothing to send
//   busy                synchronised chip select is active
// Modports: slave = the SPI target itself, master = the environment driving it.
interface spi_target_if #(
  parameter int WIDTH = 8
);
  logic             sclk;
  logic             cs;
  logic             sdi;
  logic             sdo;
  logic             sdo_oe;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             tx_underrun;
  logic             busy;

  modport slave (
    input  sclk, cs, sdi, tx_data, tx_valid,
    output sdo, sdo_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

  modport master (
    output sclk, cs, sdi, tx_data, tx_valid,
    input  sdo, sdo_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );
endinterface

// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI mode 0 target, oversampled in the clk_in domain
// Purpose: MSB-first WIDTH-bit SPI slave. sclk/cs/sdi are synchronised and
//   edge-detected in clk_in; sclk is never used as a clock. A one-word TX
//   holding register feeds the shifter; each received word is strobed out.
// Ports:
//   clk_in   system clock
//   reset_n  asynchronous active-low reset
//   bus      spi_target_if.slave (SPI pins + host TX/RX handshake)
module spi_target #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk_in,
  input  logic         reset_n,
  spi_target_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdi_sync;
  logic                   sclk_q, cs_q;
  logic                   sclk_s, cs_s, sdi_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic [WIDTH-1:0] holding, tx_shift, rx_shift, rx_data_q;
  logic             holding_full, pending_load, word_done;
  logic             rx_valid_q, underrun_q;
  logic [CW-1:0]    bit_cnt;
  logic             host_load;
  logic             do_load, do_shift, do_rx, do_abort;

  // Synchronisers plus one extra sample of sclk/cs for edge detection.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      sdi_sync  <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], bus.sdi};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = ~cs_s & cs_q;
  assign cs_rise   = cs_s & ~cs_q;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // cs_rise takes priority over any sclk edge seen in the same cycle.
  always_comb begin
    next_state = state;
    do_load    = 1'b0;
    do_shift   = 1'b0;
    do_rx      = 1'b0;
    do_abort   = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          next_state = ACTIVE;
          do_load    = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          next_state = IDLE;
          do_abort   = 1'b1;
        end else begin
          do_rx = sclk_rise;
          if (sclk_fall) begin
            do_load  = pending_load;
            do_shift = ~pending_load;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign host_load = bus.tx_valid & ~holding_full;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      holding      <= '0;
      holding_full <= 1'b0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      underrun_q   <= 1'b0;
      pending_load <= 1'b0;
      word_done    <= 1'b0;
      bit_cnt      <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      word_done  <= 1'b0;

      if (host_load) holding <= bus.tx_data;
      // A same-cycle word load drains the old value while the new one lands.
      holding_full <= host_load | (holding_full & ~do_load);

      // sdo is tx_shift's MSB, so it only moves on load, shift or abort.
      if (do_load) begin
        pending_load <= 1'b0;
        if (holding_full) begin
          tx_shift <= holding;
        end else begin
          tx_shift   <= '0;
          underrun_q <= 1'b1;
        end
      end else if (do_shift) begin
        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
      end else if (do_abort) begin
        tx_shift     <= '0;
        pending_load <= 1'b0;
      end

      if (do_abort || (do_load && state == IDLE)) bit_cnt <= '0;

      if (do_rx) begin
        rx_shift <= {rx_shift[WIDTH-2:0], sdi_s};
        if (bit_cnt == CW'(WIDTH - 1)) begin
          bit_cnt      <= '0;
          word_done    <= 1'b1;
          pending_load <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end

      if (word_done) begin
        rx_data_q  <= rx_shift;
        rx_valid_q <= 1'b1;
      end
    end
  end

  assign bus.sdo         = tx_shift[WIDTH-1];
  assign bus.sdo_oe      = ~cs_s;
  assign bus.busy        = ~cs_s;
  assign bus.tx_ready    = ~holding_full;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = underrun_q;
endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - self-checking bench for spi_target
module tb_spi_target;
  localparam int W  = 8;
  localparam int SS = 2;

  logic clk_in = 1'b0;
  logic reset_n;
  always #5 clk_in = ~clk_in;

  spi_target_if #(.WIDTH(W)) bus();

  spi_target #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;

  // Master-side view of a frame: words sent on sdi, words read from sdo.
  logic [7:0] mosi [32];
  logic [7:0] miso [32];
  logic [7:0] txw  [32];

  logic [7:0] rx_q [$];
  int         underruns = 0;

  always @(negedge clk_in) begin
    if (bus.rx_valid)    rx_q.push_back(bus.rx_data);
    if (bus.tx_underrun) underruns++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Mode 0 master. The frame ends by raising cs together with the final
  // sclk fall, so no trailing fall is seen by the target.
  task automatic spi_bits(input int nbits, input int phase, input bit end_frame);
    bus.cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      int wi = i / 8;
      int bi = 7 - (i % 8);
      bus.sdi = mosi[wi][bi];
      cycles(phase);
      bus.sclk = 1'b1;
      miso[wi][bi] = bus.sdo;
      cycles(phase);
      bus.sclk = 1'b0;
      if (end_frame && i == nbits - 1) bus.cs = 1'b1;
    end
    if (end_frame) cycles(8);
  endtask

  task automatic host_load(input logic [7:0] d);
    int t = 0;
    @(negedge clk_in);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && t < 2000) begin
      @(negedge clk_in);
      t++;
    end
    tests++;
    if (t >= 2000) begin
      fails++;
      $display("FAIL host_load_timeout: tx_ready=%b required 1", bus.tx_ready);
    end
    @(negedge clk_in);
    bus.tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cycles(3);
    reset_n = 1'b1;
    cycles(3);
    tests += 7;
    if (bus.sdo !== 1'b0)         begin fails++; $display("FAIL reset_sdo: got %b required 0", bus.sdo); end
    if (bus.sdo_oe !== 1'b0)      begin fails++; $display("FAIL reset_sdo_oe: got %b required 0", bus.sdo_oe); end
    if (bus.tx_ready !== 1'b1)    begin fails++; $display("FAIL reset_tx_ready: got %b required 1", bus.tx_ready); end
    if (bus.rx_data !== 8'h00)    begin fails++; $display("FAIL reset_rx_data: got %h required 00", bus.rx_data); end
    if (bus.rx_valid !== 1'b0)    begin fails++; $display("FAIL reset_rx_valid: got %b required 0", bus.rx_valid); end
    if (bus.tx_underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %b required 0", bus.tx_underrun); end
    if (bus.busy !== 1'b0)        begin fails++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
  endtask

  task automatic test_single_word();
    int r0 = rx_q.size();
    int u0 = underruns;
    mosi[0] = 8'h3C;
    host_load(8'hA5);
    tests++;
    if (bus.tx_ready !== 1'b0) begin fails++; $display("FAIL single_preload_ready: got %b required 0", bus.tx_ready); end
    spi_bits(8, 6, 1'b1);
    tests += 5;
    if (miso[0] !== 8'hA5) begin fails++; $display("FAIL single_miso: got %h required a5", miso[0]); end
    if (rx_q.size() - r0 != 1) begin fails++; $display("FAIL single_rx_count: got %0d required 1", rx_q.size() - r0); end
    else if (rx_q[r0] !== 8'h3C) begin fails++; $display("FAIL single_rx_data: got %h required 3c", rx_q[r0]); end
    if (bus.tx_ready !== 1'b1) begin fails++; $display("FAIL single_ready_after: got %b required 1", bus.tx_ready); end
    if (underruns != u0) begin fails++; $display("FAIL single_underrun: got %0d required 0", underruns - u0); end
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL single_busy_after: got %b required 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int r0 = rx_q.size();
    int u0 = underruns;
    mosi[0] = 8'hDE;
    mosi[1] = 8'hAD;
    host_load(8'h11);
    fork
      spi_bits(16, 6, 1'b1);
      host_load(8'h22);
    join
    tests += 5;
    if (miso[0] !== 8'h11) begin fails++; $display("FAIL b2b_miso0: got %h required 11", miso[0]); end
    if (miso[1] !== 8'h22) begin fails++; $display("FAIL b2b_miso1: got %h required 22", miso[1]); end
    if (rx_q.size() - r0 != 2) begin fails++; $display("FAIL b2b_rx_count: got %0d required 2", rx_q.size() - r0); end
    else begin
      if (rx_q[r0] !== 8'hDE)   begin fails++; $display("FAIL b2b_rx0: got %h required de", rx_q[r0]); end
      if (rx_q[r0+1] !== 8'hAD) begin fails++; $display("FAIL b2b_rx1: got %h required ad", rx_q[r0+1]); end
    end
    if (underruns != u0) begin fails++; $display("FAIL b2b_underrun: got %0d required 0", underruns - u0); end
  endtask

  task automatic test_underrun();
    int r0 = rx_q.size();
    int u0 = underruns;
    mosi[0] = 8'hFF;
    spi_bits(8, 6, 1'b1);
    tests += 3;
    if (miso[0] !== 8'h00) begin fails++; $display("FAIL underrun_miso: got %h required 00", miso[0]); end
    if (underruns - u0 != 1) begin fails++; $display("FAIL underrun_count: got %0d required 1", underruns - u0); end
    if (rx_q.size() - r0 != 1) begin fails++; $display("FAIL underrun_rx_count: got %0d required 1", rx_q.size() - r0); end
    else begin
      tests++;
      if (rx_q[r0] !== 8'hFF) begin fails++; $display("FAIL underrun_rx: got %h required ff", rx_q[r0]); end
    end
  endtask

  task automatic test_abort();
    int r0 = rx_q.size();
    logic [7:0] pre = 8'h5A;
    logic [7:0] p2;
    mosi[0] = 8'($urandom);
    host_load(pre);
    spi_bits(5, 6, 1'b1);
    tests += 4;
    if (rx_q.size() != r0) begin fails++; $display("FAIL abort_no_rx: got %0d strobes required 0", rx_q.size() - r0); end
    if (bus.sdo !== 1'b0)  begin fails++; $display("FAIL abort_sdo: got %b required 0", bus.sdo); end
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_idle: busy=%b required 0", bus.busy); end
    if (miso[0][7:3] !== pre[7:3]) begin fails++; $display("FAIL abort_partial_miso: got %b required %b", miso[0][7:3], pre[7:3]); end
    p2 = 8'($urandom);
    mosi[0] = 8'h81;
    host_load(p2);
    spi_bits(8, 6, 1'b1);
    tests += 2;
    if (miso[0] !== p2) begin fails++; $display("FAIL abort_next_miso: got %h required %h", miso[0], p2); end
    if (bus.rx_data !== 8'h81) begin fails++; $display("FAIL abort_next_rx: got %h required 81", bus.rx_data); end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] m;
    mosi[0] = 8'($urandom);
    host_load(8'($urandom));
    spi_bits(3, 6, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    tests += 6;
    if (bus.sdo !== 1'b0)      begin fails++; $display("FAIL midrst_sdo: got %b required 0", bus.sdo); end
    if (bus.sdo_oe !== 1'b0)   begin fails++; $display("FAIL midrst_sdo_oe: got %b required 0", bus.sdo_oe); end
    if (bus.busy !== 1'b0)     begin fails++; $display("FAIL midrst_busy: got %b required 0", bus.busy); end
    if (bus.tx_ready !== 1'b1) begin fails++; $display("FAIL midrst_tx_ready: got %b required 1", bus.tx_ready); end
    if (bus.rx_data !== 8'h00) begin fails++; $display("FAIL midrst_rx_data: got %h required 00", bus.rx_data); end
    if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL midrst_rx_valid: got %b required 0", bus.rx_valid); end
    bus.cs   = 1'b1;
    bus.sclk = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    cycles(4);
    m = 8'($urandom);
    mosi[0] = m;
    host_load(8'hC3);
    spi_bits(8, 6, 1'b1);
    tests += 2;
    if (miso[0] !== 8'hC3) begin fails++; $display("FAIL midrst_after_miso: got %h required c3", miso[0]); end
    if (bus.rx_data !== m) begin fails++; $display("FAIL midrst_after_rx: got %h required %h", bus.rx_data, m); end
  endtask

  task automatic test_stream_min_phase();
    int r0 = rx_q.size();
    int u0 = underruns;
    for (int k = 0; k < 32; k++) begin
      txw[k]  = 8'($urandom);
      mosi[k] = 8'($urandom);
    end
    host_load(txw[0]);
    fork
      spi_bits(256, SS + 2, 1'b1);
      for (int k = 1; k < 32; k++) host_load(txw[k]);
    join
    tests += 2;
    if (rx_q.size() - r0 != 32) begin fails++; $display("FAIL stream_rx_count: got %0d required 32", rx_q.size() - r0); end
    if (underruns != u0) begin fails++; $display("FAIL stream_underrun: got %0d required 0", underruns - u0); end
    for (int k = 0; k < 32; k++) begin
      tests++;
      if (miso[k] !== txw[k]) begin fails++; $display("FAIL stream_miso[%0d]: got %h required %h", k, miso[k], txw[k]); end
      tests++;
      if (r0 + k >= rx_q.size()) begin fails++; $display("FAIL stream_rx[%0d]: got none required %h", k, mosi[k]); end
      else if (rx_q[r0+k] !== mosi[k]) begin fails++; $display("FAIL stream_rx[%0d]: got %h required %h", k, rx_q[r0+k], mosi[k]); end
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.sclk     = 1'b0;
    bus.cs       = 1'b1;
    bus.sdi      = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_mid_word();
    test_stream_min_phase();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
